alu_seq: RTL and testbench

- Execution-side responder for the RV32I register-register/immediate ALU interface.
- Consumes the operation request (enable, funct3, operands) driven by the decode stage or bench.
- Returns a registered result with a valid strobe.
- Logic/arithmetic ops take one cycle. Shifts use an iterative 1-bit-per-cycle shifter, for area, with a busy indication.

---
 rtl/alu_seq.sv | 82 ++++++++
 tb/tb_alu_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: RV32I ALU responder; single-cycle logic/arith, iterative 1-bit-per-cycle shifter
module alu_seq #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [2:0]         funct3,
  input  logic               funct7_5,
  input  logic [XLEN-1:0]    register_data_1,
  input  logic [XLEN-1:0]    register_data_2,
  output logic [XLEN-1:0]    register_data_out,
  output logic               valid,
  output logic               busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  logic [1:0]         state;
  logic [SHAMT_W-1:0] cnt;
  logic [XLEN-1:0]    sreg;
  logic               left;
  logic               arith;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    sh_next;
  logic [SHAMT_W-1:0] shamt;
  logic               is_shift;
  assign busy     = state == SHIFT;
  assign shamt    = register_data_2[SHAMT_W-1:0];
  assign is_shift = funct3 == 3'b001 || funct3 == 3'b101;
  assign sh_next  = left ? {sreg[XLEN-2:0], 1'b0} : {arith & sreg[XLEN-1], sreg[XLEN-1:1]};
  // Shift opcodes fall through to operand A so that a zero shift amount completes in one cycle.
  always_comb begin
    alu_res = register_data_1;
    case (funct3)
      3'b000: alu_res = funct7_5 ? register_data_1 - register_data_2 : register_data_1 + register_data_2;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(register_data_1) < $signed(register_data_2)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, register_data_1 < register_data_2};
      3'b100: alu_res = register_data_1 ^ register_data_2;
      3'b110: alu_res = register_data_1 | register_data_2;
      3'b111: alu_res = register_data_1 & register_data_2;
      default: alu_res = register_data_1;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      cnt               <= '0;
      sreg              <= '0;
      left              <= 1'b0;
      arith             <= 1'b0;
      register_data_out <= '0;
      valid             <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          if (is_shift && shamt != '0) begin
            sreg  <= register_data_1;
            cnt   <= shamt;
            left  <= funct3 == 3'b001;
            arith <= funct7_5;
            state <= SHIFT;
          end else begin
            register_data_out <= alu_res;
            valid             <= 1'b1;
          end
        end
        SHIFT: begin
          sreg <= sh_next;
          cnt  <= cnt - 1'b1;
          if (cnt == SHAMT_W'(1)) begin
            register_data_out <= sh_next;
            valid             <= 1'b1;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table vectors, hand-written shift/reset sequences and randomized ops vs a reference model
module tb_alu_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic [31:0] register_data_1 = '0;
  logic [31:0] register_data_2 = '0;
  logic [31:0] register_data_out;
  logic        valid;
  logic        busy;
  int n_checks = 0;
  int n_fail = 0;

  alu_seq #(.XLEN(32), .SHAMT_W(5)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .funct3(funct3), .funct7_5(funct7_5),
    .register_data_1(register_data_1), .register_data_2(register_data_2),
    .register_data_out(register_data_out), .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = int'(b % 32);
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << n;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> n) : a >> n;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic drive(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b);
    enable = 1'b1; funct3 = f3; funct7_5 = f7; register_data_1 = a; register_data_2 = b;
  endtask

  // Issue one op, expect valid `lat` edges after the capture edge, then one idle cycle with valid low.
  task automatic do_op(input string name, input logic [2:0] f3, input logic f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    @(negedge clock);
    drive(f3, f7, a, b);
    @(posedge clock); #1;
    enable = 1'b0;
    register_data_1 = $urandom; register_data_2 = $urandom; funct3 = 3'($urandom);
    k = 0;
    while (!valid && k < 40) begin
      check({name, "_busy"}, 32'(busy), 32'd1);
      @(posedge clock); #1;
      k++;
    end
    check({name, "_lat"}, k, lat);
    check({name, "_out"}, register_data_out, exp);
    check({name, "_busy_done"}, 32'(busy), 32'd0);
    @(posedge clock); #1;
    check({name, "_pulse"}, 32'(valid), 32'd0);
  endtask

  vec_t vecs[$];
  int pulses;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check("rst_out", register_data_out, 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clock); reset_n = 1'b1;

    vecs.push_back('{3'd0, 1'b0, 32'd1, 32'd2, 32'd3});
    vecs.push_back('{3'd0, 1'b1, 32'd1, 32'd2, 32'hFFFFFFFF});
    vecs.push_back('{3'd2, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd1});
    vecs.push_back('{3'd3, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0});
    vecs.push_back('{3'd2, 1'b1, 32'd5, 32'd5, 32'd0});
    vecs.push_back('{3'd0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0});
    vecs.push_back('{3'd1, 1'b1, 32'h12345678, 32'hFFFFFFE0, 32'h12345678});
    vecs.push_back('{3'd5, 1'b1, 32'h87654321, 32'd0, 32'h87654321});
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, vecs[i].exp, 0);

    // Logic ops back-to-back: three consecutive pulses.
    @(negedge clock); drive(3'd4, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0);
    @(posedge clock); #1;
    check("b2b_xor_v", 32'(valid), 32'd1); check("b2b_xor", register_data_out, 32'hFF00FF00);
    @(negedge clock); drive(3'd6, 1'b1, 32'hF0F0F0F0, 32'h0FF00FF0);
    @(posedge clock); #1;
    check("b2b_or_v", 32'(valid), 32'd1); check("b2b_or", register_data_out, 32'hFFF0FFF0);
    @(negedge clock); drive(3'd7, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0);
    @(posedge clock); #1;
    check("b2b_and_v", 32'(valid), 32'd1); check("b2b_and", register_data_out, 32'h00F000F0);
    @(negedge clock); enable = 1'b0;
    @(posedge clock); #1;
    check("b2b_end_v", 32'(valid), 32'd0);

    do_op("sll31", 3'd1, 1'b0, 32'd1, 32'd31, 32'h80000000, 31);
    do_op("srl4", 3'd5, 1'b0, 32'h80000000, 32'd4, 32'h08000000, 4);

    // SRA with an ADD request injected while busy: one pulse, shift result.
    @(negedge clock); drive(3'd5, 1'b1, 32'h80000000, 32'd4);
    @(negedge clock); drive(3'd0, 1'b0, 32'd7, 32'd8);
    pulses = 0;
    @(negedge clock); enable = 1'b0;
    repeat (10) begin
      @(posedge clock); #1;
      if (valid) begin
        pulses++;
        check("sra_out", register_data_out, 32'hF8000000);
      end
    end
    check("sra_pulses", pulses, 1);
    check("sra_hold", register_data_out, 32'hF8000000);

    // SRL N=1 then ADD issued the cycle busy falls.
    @(negedge clock); drive(3'd5, 1'b0, 32'h00000010, 32'd1);
    @(posedge clock); #1;
    check("bb_busy", 32'(busy), 32'd1);
    check("bb_v0", 32'(valid), 32'd0);
    drive(3'd0, 1'b0, 32'd100, 32'd23);
    @(posedge clock); #1;
    check("bb_srl_v", 32'(valid), 32'd1);
    check("bb_srl", register_data_out, 32'h00000008);
    check("bb_busy_low", 32'(busy), 32'd0);
    @(posedge clock); #1;
    enable = 1'b0;
    check("bb_add_v", 32'(valid), 32'd1);
    check("bb_add", register_data_out, 32'd123);
    @(posedge clock); #1;
    check("bb_end_v", 32'(valid), 32'd0);

    for (int i = 0; i < 150; i++) begin
      logic [2:0] f3; logic f7; logic [31:0] a, b; int lat;
      f3 = 3'($urandom); f7 = 1'($urandom); a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 2));
      lat = (f3 == 3'd1 || f3 == 3'd5) ? int'(b % 32) : 0;
      do_op($sformatf("rnd%0d_f%0d", i, f3), f3, f7, a, b, model(f3, f7, a, b), lat);
    end

    // Reset mid-shift: outputs clear at once and the aborted shift never completes.
    @(negedge clock); drive(3'd1, 1'b0, 32'h0000ABCD, 32'd20);
    @(negedge clock); enable = 1'b0;
    repeat (4) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_out", register_data_out, 32'd0);
    @(negedge clock); reset_n = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (valid) pulses++;
    end
    check("mid_rst_pulses", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
